seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_pattern_detector.sv | 128 ++++++++++++
 tb/tb_seq_pattern_detector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with a runtime-loadable pattern and KMP-style fallback.
// It supports Mealy or Moore match output and a saturating match counter.
module seq_pattern_detector #(
    parameter int                 PAT_LEN   = 4,
    parameter int                 CNT_W     = 8,
    parameter bit                 MOORE     = 1'b0,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               count_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);

    localparam int               KW      = $clog2(PAT_LEN + 1);
    localparam logic [KW-1:0]    K_FULL  = KW'(PAT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [KW-1:0]      k_q, k_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_LEN-1:0] seq;
    logic [KW-1:0]      k_eff;
    logic [PAT_LEN:1]   pre_hit;
    logic [KW-1:0]      best_proper;
    logic               full_hit;
    logic               hit;

    // Newest bit sits at seq[0]; older history bits sit above it.
    assign seq = {hist_q, in_bit};

    // Moore state PAT_LEN after a non-overlapping match behaves like k=0,
    // because the history was wiped when the match completed.
    assign k_eff = (k_q == K_FULL && !ovl_q) ? '0 : k_q;

    // A prefix of length gi can only match if the previous state is at least gi-1.
    genvar gi;
    generate
        for (gi = 1; gi <= PAT_LEN; gi++) begin : g_prefix
            assign pre_hit[gi] = (k_eff >= KW'(gi - 1)) &&
                                 (seq[gi-1:0] == pat_q[PAT_LEN-1:PAT_LEN-gi]);
        end
    endgenerate

    always_comb begin
        best_proper = '0;
        for (int j = 1; j < PAT_LEN; j++) begin
            if (pre_hit[j]) begin
                best_proper = KW'(j);
            end
        end
    end

    assign full_hit = pre_hit[PAT_LEN];
    assign hit      = in_valid && !cfg_we && full_hit;

    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        k_d    = k_q;
        hist_d = hist_q;
        if (cfg_we) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            k_d    = '0;
            hist_d = '0;
        end else if (in_valid) begin
            hist_d = seq[PAT_LEN-2:0];
            k_d    = best_proper;
            if (full_hit) begin
                if (MOORE) begin
                    k_d = K_FULL;
                end
                if (!ovl_q) begin
                    hist_d = '0;
                    if (!MOORE) begin
                        k_d = '0;
                    end
                end
            end
        end
    end

    // A clear that coincides with a new match leaves the count at one.
    always_comb begin
        cnt_d = cnt_q;
        if (count_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
        end else if (hit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        match = 1'b0;
        if (!reset && !cfg_we) begin
            match = MOORE ? (k_q == K_FULL) : (in_valid && full_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q  <= PAT_RESET;
            ovl_q  <= 1'b1;
            k_q    <= '0;
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            k_q    <= k_d;
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Mealy, Moore and narrow-counter detectors share one stimulus stream.
// A stream-level model, which compares the last four received bits with the pattern, checks them.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset, cfg_we, cfg_overlap, in_valid, in_bit, count_clr;
    logic [3:0] cfg_pattern;
    logic       m_mealy, m_moore, m_sat;
    logic [7:0] c_mealy, c_moore;
    logic [1:0] c_sat;

    always #5 clk = ~clk;

    seq_pattern_detector #(.PAT_LEN(4), .CNT_W(8), .MOORE(1'b0)) u_mealy (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .count_clr(count_clr), .match(m_mealy), .match_count(c_mealy)
    );

    seq_pattern_detector #(.PAT_LEN(4), .CNT_W(8), .MOORE(1'b1)) u_moore (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .count_clr(count_clr), .match(m_moore), .match_count(c_moore)
    );

    seq_pattern_detector #(.PAT_LEN(4), .CNT_W(2), .MOORE(1'b0)) u_sat (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
        .count_clr(count_clr), .match(m_sat), .match_count(c_sat)
    );

    // Model: received bits since the last clear, the pattern, the overlap mode, and the counts.
    bit       mq[$];
    bit [3:0] m_pat  = 4'b1011;
    bit       m_ovl  = 1'b1;
    bit       m_flag = 1'b0;
    int       m_cnt8 = 0;
    int       m_cnt2 = 0;
    int       n_checks = 0;
    int       n_pass   = 0;
    int       cyc      = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic bit completes(input bit b);
        bit [3:0] w;
        int       n;
        n = mq.size();
        if (n < 3) return 1'b0;
        w = {mq[n-3], mq[n-2], mq[n-1], b};
        return w == m_pat;
    endfunction

    task automatic step(input bit rst, input bit we, input bit [3:0] pat, input bit ovl,
                        input bit v, input bit b, input bit clr);
        bit hit, inc;
        @(negedge clk);
        reset = rst; cfg_we = we; cfg_pattern = pat; cfg_overlap = ovl;
        in_valid = v; in_bit = b; count_clr = clr;
        #2;
        hit = completes(b);
        chk("mealy_match", int'(m_mealy), int'(!rst && !we && v && hit));
        chk("moore_match", int'(m_moore), int'(!rst && !we && m_flag));
        chk("sat_match",   int'(m_sat),   int'(!rst && !we && v && hit));
        @(posedge clk);
        #1;
        inc = 1'b0;
        if (rst) begin
            mq.delete();
            m_pat = 4'b1011; m_ovl = 1'b1; m_flag = 1'b0;
            m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            if (we) begin
                mq.delete();
                m_pat = pat; m_ovl = ovl; m_flag = 1'b0;
            end else if (v) begin
                mq.push_back(b);
                if (mq.size() > 4) void'(mq.pop_front());
                if (hit && !m_ovl) mq.delete();
                m_flag = hit;
                inc    = hit;
            end
            if (clr) begin
                m_cnt8 = inc ? 1 : 0;
                m_cnt2 = inc ? 1 : 0;
            end else if (inc) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
        chk("mealy_count", int'(c_mealy), m_cnt8);
        chk("moore_count", int'(c_moore), m_cnt8);
        chk("sat_count",   int'(c_sat),   m_cnt2);
        $display("cyc %0d rst=%0b we=%0b pat=%b ovl=%0b v=%0b bit=%0b clr=%0b | mealy=%0b moore=%0b cnt=%0d/%0d sat=%0d",
                 cyc, rst, we, pat, ovl, v, b, clr, m_mealy, m_moore, c_mealy, c_moore, c_sat);
        cyc++;
    endtask

    task automatic send(input bit [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 4'b0, 1'b0, 1'b1, bits[i], 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; in_bit = 1'b0; count_clr = 1'b0;

        do_reset();
        chk("rst_count", int'(c_mealy), 0);
        chk("rst_moore", int'(m_moore), 0);

        // Overlapping stream 1,0,1,1,0,1,1
        send(16'b1011011, 7);
        chk("ovl_count", int'(c_mealy), 2);

        // Non-overlapping mode on the same stream
        do_reset();
        step(1'b0, 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        send(16'b1011011, 7);
        chk("novl_count", int'(c_mealy), 1);

        // Fallback from k=3 to k=2
        do_reset();
        send(16'b101011, 6);
        chk("fallback_count", int'(c_mealy), 1);

        // Moore output holds through idle cycles
        do_reset();
        send(16'b1011, 4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("moore_hold", int'(m_moore), 1);
        chk("moore_cnt", int'(c_moore), 1);

        // Narrow counter saturation, then clear, then clear together with a match
        do_reset();
        for (int g = 0; g < 5; g++) begin
            send(16'b1011, 4);
            chk("sat_seq", int'(c_sat), (g < 3) ? g + 1 : 3);
        end
        step(1'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_clr", int'(c_sat), 0);
        send(16'b101, 3);
        step(1'b0, 1'b0, 4'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_with_match", int'(c_sat), 1);

        // Reset mid-pattern restarts detection from scratch
        do_reset();
        send(16'b101, 3);
        do_reset();
        send(16'b1011, 4);
        chk("midrst_count", int'(c_mealy), 1);

        // A configuration write mid-pattern behaves the same way
        do_reset();
        send(16'b101, 3);
        step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0);
        send(16'b1011, 4);
        chk("midcfg_count", int'(c_mealy), 1);

        // A configuration write coinciding with the completing bit drops that bit
        do_reset();
        send(16'b101, 3);
        step(1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("cfgdrop_count", int'(c_mealy), 0);

        // Random traffic with occasional reconfiguration, clears and resets
        for (int i = 0; i < 1500; i++) begin
            bit       r_rst, r_we, r_ovl, r_v, r_b, r_clr;
            bit [3:0] r_pat;
            r_rst = ($urandom_range(0, 199) == 0);
            r_we  = ($urandom_range(0, 39) == 0);
            r_pat = 4'($urandom);
            r_ovl = 1'($urandom);
            r_v   = ($urandom_range(0, 3) != 0);
            r_b   = 1'($urandom);
            r_clr = ($urandom_range(0, 29) == 0);
            step(r_rst, r_we, r_pat, r_ovl, r_v, r_b, r_clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
